// File: rtl/hps_triple_sequencer_pkg.sv
// Shared types and default sizing for the HPS triple sequencer.
package hps_triple_sequencer_pkg;

    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_ADDR_WIDTH      = 10;
    localparam int DEF_NUM_BINS        = 1024;
    localparam int DEF_RAM_LATENCY     = 1;
    // Matches the depth of the downstream triple-product multiplier chain.
    localparam int DEF_PRODUCT_LATENCY = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

    // Which member of the current triple is on rd_addr this cycle.
    typedef enum logic [1:0] {
        PH_K  = 2'd0,
        PH_2K = 2'd1,
        PH_3K = 2'd2
    } phase_t;

    // Largest fundamental whose third harmonic still lies inside the spectrum.
    function automatic int k_max(input int num_bins);
        return (num_bins - 1) / 3;
    endfunction

endpackage

// File: rtl/hps_triple_sequencer_shift_reg.sv
// Fixed-depth register delay line with asynchronous clear.
module hps_triple_sequencer_shift_reg #(
    parameter int WIDTH = 1,
    parameter int DELAY = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DELAY-1:0][WIDTH-1:0] stages;

    // Shift one stage per clock; reset flushes every stage so nothing stale emerges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stages <= '0;
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DELAY; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DELAY-1];

endmodule

// File: rtl/hps_triple_sequencer.sv
// Sweeps the magnitude RAM as (k, 2k, 3k) triples for the HPS multiplier and
// emits a product strobe/bin aligned with the multiplier output.
module hps_triple_sequencer
    import hps_triple_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int NUM_BINS        = DEF_NUM_BINS,
    parameter int RAM_LATENCY     = DEF_RAM_LATENCY,
    parameter int PRODUCT_LATENCY = DEF_PRODUCT_LATENCY
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  triple_last,
    output logic                  prod_valid,
    output logic [ADDR_WIDTH-1:0] prod_bin
);

    localparam logic [ADDR_WIDTH-1:0] K_MAX = ADDR_WIDTH'(k_max(NUM_BINS));
    localparam logic [ADDR_WIDTH-1:0] K_ONE = ADDR_WIDTH'(1);

    seq_state_t            state, state_nxt;
    phase_t                phase, phase_nxt;
    logic [ADDR_WIDTH-1:0] k, k_nxt;
    logic [ADDR_WIDTH-1:0] addr, addr_nxt;

    logic [RAM_LATENCY:1]  vld_pipe;
    logic [ADDR_WIDTH-1:0] data_bin;

    // FSM, fundamental counter, phase counter and address register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            phase <= PH_K;
            k     <= K_ONE;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            k     <= k_nxt;
            addr  <= addr_nxt;
        end
    end

    // Next-state logic: 2k and 3k come from shift/add on the held address, no multiplier.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        k_nxt     = k;
        addr_nxt  = addr;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_READ;
                    phase_nxt = PH_K;
                    k_nxt     = K_ONE;
                    addr_nxt  = K_ONE;
                end
            end
            ST_READ: begin
                case (phase)
                    PH_K: begin
                        phase_nxt = PH_2K;
                        addr_nxt  = k << 1;
                    end
                    PH_2K: begin
                        phase_nxt = PH_3K;
                        addr_nxt  = addr + k;
                    end
                    default: begin
                        phase_nxt = PH_K;
                        if (k == K_MAX) begin
                            state_nxt = ST_DRAIN;
                            addr_nxt  = '0;
                        end else begin
                            k_nxt    = k + K_ONE;
                            addr_nxt = k + K_ONE;
                        end
                    end
                endcase
            end
            ST_DRAIN: begin
                // Only the final triple's product carries bin K_MAX.
                if (prod_valid && (prod_bin == K_MAX)) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                    k_nxt     = K_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign rd_en   = (state == ST_READ);
    assign rd_addr = addr;
    assign busy    = (state != ST_IDLE);

    // Track when rd_data holds a requested word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_en;
            for (int i = 2; i <= RAM_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    // Register RAM data once; hold between valid words.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= '0;
        end else if (vld_pipe[RAM_LATENCY]) begin
            data_out <= rd_data;
        end
    end

    // Align strobe, triple marker and fundamental with data_out.
    hps_triple_sequencer_shift_reg #(
        .WIDTH (ADDR_WIDTH + 2),
        .DELAY (RAM_LATENCY + 1)
    ) u_data_dly (
        .clock   (clock),
        .reset_n (reset_n),
        .din     ({rd_en, rd_en && (phase == PH_3K), k}),
        .dout    ({data_valid, triple_last, data_bin})
    );

    // Align triple completion with the multiplier's product output.
    hps_triple_sequencer_shift_reg #(
        .WIDTH (ADDR_WIDTH + 1),
        .DELAY (PRODUCT_LATENCY)
    ) u_prod_dly (
        .clock   (clock),
        .reset_n (reset_n),
        .din     ({triple_last, data_bin}),
        .dout    ({prod_valid, prod_bin})
    );

endmodule

// File: tb/tb_hps_triple_sequencer.sv
// Bench for hps_triple_sequencer with a small spectrum, a RAM model and a
// downstream triple-product model.
module tb_hps_triple_sequencer;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NB = 16;
    localparam int KM = (NB - 1) / 3;
    localparam int SWEEP_END = 33;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, rd_en, data_valid, triple_last, prod_valid;
    logic [AW-1:0] rd_addr, prod_bin;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] data_out;

    logic [DW-1:0] mem [0:NB-1];
    int            exp_addr[$];
    longint unsigned words[$];
    longint unsigned prods[$];
    int checks = 0;
    int passed = 0;

    hps_triple_sequencer #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .NUM_BINS        (NB),
        .RAM_LATENCY     (1),
        .PRODUCT_LATENCY (16)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .triple_last (triple_last),
        .prod_valid  (prod_valid),
        .prod_bin    (prod_bin)
    );

    always #5 clock = ~clock;

    // One-cycle-latency magnitude RAM.
    always @(posedge clock) begin
        if (rd_en) rd_data <= mem[rd_addr[3:0]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic longint unsigned triple_prod(input int b);
        return longint'(mem[b]) * longint'(mem[2*b]) * longint'(mem[3*b]);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".rd_en"}, rd_en, 0);
        check({tag, ".rd_addr"}, rd_addr, 0);
        check({tag, ".data_out"}, data_out, 0);
        check({tag, ".data_valid"}, data_valid, 0);
        check({tag, ".triple_last"}, triple_last, 0);
        check({tag, ".prod_valid"}, prod_valid, 0);
        check({tag, ".prod_bin"}, prod_bin, 0);
    endtask

    // Pulse start and follow the sweep cycle by cycle against the expected timeline.
    // r = 0 is the first address cycle; returns in the cycle busy has fallen (no tick).
    task automatic run_sweep(input bit spur, input bit start_on_done);
        words.delete();
        prods.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r <= SWEEP_END; r++) begin
            bit exp_rd, exp_dv, exp_pv;
            exp_rd = (r < 3*KM);
            exp_dv = (r >= 2) && (r < 3*KM + 2);
            exp_pv = (r >= 20) && (r <= 20 + 3*(KM-1)) && ((r - 20) % 3 == 0);

            check("rd_en", rd_en, exp_rd);
            if (exp_rd) check("rd_addr", rd_addr, exp_addr[r]);
            check("data_valid", data_valid, exp_dv);
            if (exp_dv) begin
                check("data_out", data_out, mem[exp_addr[r-2]]);
                check("triple_last", triple_last, ((r - 2) % 3 == 2));
            end else begin
                check("triple_last_idle", triple_last, 0);
            end
            check("prod_valid", prod_valid, exp_pv);
            if (exp_pv) check("prod_bin", prod_bin, (r - 20) / 3 + 1);
            check("done", done, (r == 20 + 3*(KM-1)));
            check("busy", busy, (r <= 20 + 3*(KM-1)));

            // Downstream multiplier model: multiply the words of each triple.
            if (data_valid) words.push_back(longint'(data_out));
            if (data_valid && triple_last) begin
                longint unsigned p;
                p = 1;
                foreach (words[i]) p = p * words[i];
                words.delete();
                prods.push_back(p);
            end
            if (prod_valid && exp_pv) begin
                longint unsigned got;
                got = (prods.size() > 0) ? prods.pop_front() : 0;
                check("product", got, triple_prod((r - 20) / 3 + 1));
            end

            if (r < SWEEP_END) begin
                start = (spur && r >= 1 && r <= 31 && $urandom_range(0, 2) == 0) ||
                        (start_on_done && r == 20 + 3*(KM-1));
                tick();
            end
            start = 1'b0;
        end
    endtask

    initial begin
        for (int k = 1; k <= KM; k++) begin
            exp_addr.push_back(k);
            exp_addr.push_back(2*k);
            exp_addr.push_back(3*k);
        end
        for (int i = 0; i < NB; i++) mem[i] = DW'(i);

        // Reset state
        #3 reset_n = 1'b0;
        #1 check_all_zero("reset");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check_all_zero("idle");

        // Nominal sweep with mem[i] = i: products 6,48,162,384,750
        check("ref_prod1", triple_prod(1), 6);
        check("ref_prod5", triple_prod(5), 750);
        run_sweep(1'b0, 1'b0);
        tick();
        check("post.busy", busy, 0);
        check("post.rd_en", rd_en, 0);

        // Random magnitudes, spurious starts in READ/DRAIN and on the done cycle
        for (int i = 0; i < NB; i++) mem[i] = DW'($urandom_range(1, 65535));
        run_sweep(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nosweep.rd_en", rd_en, 0);
            check("nosweep.busy", busy, 0);
            check("nosweep.done", done, 0);
        end

        // Back-to-back sweeps: start in the cycle busy has fallen
        for (int i = 0; i < NB; i++) mem[i] = DW'($urandom_range(1, 65535));
        run_sweep(1'b0, 1'b0);
        run_sweep(1'b0, 1'b0);

        // Reset in the middle of READ
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat ($urandom_range(2, 12)) tick();
        check("midread.rd_en", rd_en, 1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("midreset");
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            check("abort.done", done, 0);
            check("abort.prod_valid", prod_valid, 0);
            check("abort.rd_en", rd_en, 0);
        end
        run_sweep(1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
